// File: rtl/lu_rr_arbiter.sv
// Purpose : shares one registered bitwise logic unit between two requesters, choosing between them round-robin.
// Latency : the result is valid one cycle after the accepting edge (ack), so the minimum is one operation per 3 cycles.
// Backpr. : the result is held in WAIT until res_ready; requests that arrive while busy are not queued, so requesters keep req high.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req0/op0/a0/b0, ack0   requester 0 request bundle and one-cycle accept pulse
//   req1/op1/a1/b1, ack1   requester 1 request bundle and one-cycle accept pulse
//   res, res_id, res_valid result, owning requester, valid (valid/ready with res_ready)
//   busy                   high while an operation is in flight (EXEC or WAIT)
//
// Opcodes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 NOT b.

module lu_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic [WIDTH-1:0] res,
    output logic             res_id,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_id;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ack0;
    logic             r_ack1;
    logic [WIDTH-1:0] r_res;
    logic             r_res_id;
    logic             r_res_valid;
    logic             r_busy;

    logic             w_any_req;
    logic             w_winner;
    logic [2:0]       w_win_op;
    logic [WIDTH-1:0] w_win_a;
    logic [WIDTH-1:0] w_win_b;
    logic [WIDTH-1:0] w_lu_res;

    // On a tie the requester that was not served last wins. r_last_id
    // resets to 1, so requester 0 wins the first tie.
    assign w_any_req = req0 | req1;
    assign w_winner  = (req0 & req1) ? ~r_last_id : req1;
    assign w_win_op  = w_winner ? op1 : op0;
    assign w_win_a   = w_winner ? a1  : a0;
    assign w_win_b   = w_winner ? b1  : b0;

    // The logic unit works only on the latched operands, so changes to the
    // inputs after the accepting edge have no effect.
    always_comb begin
        w_lu_res = '0;
        case (r_op)
            3'd0:    w_lu_res = r_a & r_b;
            3'd1:    w_lu_res = ~(r_a & r_b);
            3'd2:    w_lu_res = r_a | r_b;
            3'd3:    w_lu_res = ~(r_a | r_b);
            3'd4:    w_lu_res = r_a ^ r_b;
            3'd5:    w_lu_res = ~(r_a ^ r_b);
            3'd6:    w_lu_res = ~r_a;
            default: w_lu_res = ~r_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_id   <= 1'b1;
            r_op        <= 3'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_res       <= '0;
            r_res_id    <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_op     <= w_win_op;
                        r_a      <= w_win_a;
                        r_b      <= w_win_b;
                        r_res_id <= w_winner;
                        r_ack0   <= ~w_winner;
                        r_ack1   <= w_winner;
                        r_busy   <= 1'b1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res       <= w_lu_res;
                    r_res_valid <= 1'b1;
                    r_ack0      <= 1'b0;
                    r_ack1      <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // The round-robin pointer advances only when a result is
                    // delivered. An aborted operation does not count.
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_last_id   <= r_res_id;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign res       = r_res;
    assign res_id    = r_res_id;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;

endmodule
